// File: rtl/nano_mem_responder.sv
// nano_mem_responder
//   Memory-side responder for the NanoCPU bus. Holds a DEPTH x DATA_W RAM
//   with combinational (zero-wait-state) reads and single-cycle writes, and
//   snoops CPU writes landing in a result window [OUT_BASE, OUT_BASE+OUT_LEN).
//   Each snooped {address,data} pair is queued in a small FIFO that drains
//   over a valid/ready stream, so results leave without the CPU polling.
//
// Ports
//   ck, rst                 clock (posedge), asynchronous active-high reset
//   ce, we, address, dataW  CPU access strobe, write enable, address, write data
//   dataR                   mem[address], combinational, independent of ce/we
//   load_en/addr/data       preload write port; a CPU write to the same address
//                           in the same cycle wins; preloads are never snooped
//   out_valid/ready/addr/data  snoop stream
//   fifo_count              entries currently queued (0..FIFO_DEPTH)
//   overflow                sticky flag: a snooped write was dropped (FIFO full)
//
// Stream handshake: an entry transfers on a rising edge of ck where
// out_valid & out_ready are both high. out_valid depends only on registered
// state, never on out_ready; out_addr/out_data are stable while out_valid is
// high and not accepted. When empty, out_* hold stale values (don't-care).
module nano_mem_responder #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int OUT_BASE   = 15,
  parameter int OUT_LEN    = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          ck,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          we,
  input  logic [ADDR_W-1:0]             address,
  input  logic [DATA_W-1:0]             dataW,
  output logic [DATA_W-1:0]             dataR,
  input  logic                          load_en,
  input  logic [ADDR_W-1:0]             load_addr,
  input  logic [DATA_W-1:0]             load_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_W-1:0]             out_addr,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Window bounds carry one extra bit so OUT_BASE+OUT_LEN cannot wrap.
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(OUT_BASE);
  localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(OUT_BASE + OUT_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // RAM (not reset; contents survive rst)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              cpu_wr;

  assign cpu_wr = ce & we;
  assign dataR  = mem_q[address];

  // The CPU write is issued after the preload so it wins on an address clash.
  always_ff @(posedge ck) begin
    if (load_en) mem_q[load_addr] <= load_data;
    if (cpu_wr)  mem_q[address]   <= dataW;
  end

  // ---------------------------------------------------------------------------
  // Snoop FIFO
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [ADDR_W:0]   addr_ext;
  logic              snoop_hit;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  assign addr_ext  = {1'b0, address};
  assign snoop_hit = cpu_wr && (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
  assign full      = (count_q == CNT_FULL);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = snoop_hit & (~full | pop);
  assign drop      = snoop_hit & full & ~pop;

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = address;
      fifo_data_d[wr_ptr_q] = dataW;
    end
    // Pointer width equals log2(FIFO_DEPTH), so increments wrap naturally.
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      fifo_addr_q <= '{default: '0};
      fifo_data_q <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Head comes straight from registered storage: no same-cycle bypass.
  assign out_addr   = fifo_addr_q[rd_ptr_q];
  assign out_data   = fifo_data_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_nano_mem_responder.sv
module tb_nano_mem_responder;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int OUT_BASE   = 15;
  localparam int OUT_LEN    = 10;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic ck = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  logic                ce, we, load_en, out_ready;
  logic [ADDR_W-1:0]   address, load_addr;
  logic [DATA_W-1:0]   dataW, load_data;
  logic [DATA_W-1:0]   dataR;
  logic                out_valid, overflow;
  logic [ADDR_W-1:0]   out_addr;
  logic [DATA_W-1:0]   out_data;
  logic [CNT_W-1:0]    fifo_count;

  nano_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_BASE(OUT_BASE),
    .OUT_LEN(OUT_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .ck(ck), .rst(rst), .ce(ce), .we(we), .address(address), .dataW(dataW),
    .dataR(dataR), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .fifo_count(fifo_count), .overflow(overflow)
  );

  // ---------------------------------------------------------------------------
  // Reference model: RAM array, expected queue of {addr,data}, sticky flag
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]        ref_mem [2**ADDR_W];
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic                     ref_ovf;
  int                       n_cmp = 0;
  int                       n_bad = 0;

  // One clock edge: capture the inputs, clock the DUT, apply the same
  // transaction to the model, and return 1 time unit after the edge.
  task automatic step();
    logic              c_wr, c_ld, c_pop, c_hit;
    logic [ADDR_W-1:0] c_a, c_la;
    logic [DATA_W-1:0] c_d, c_ld_d;
    c_wr  = ce && we;
    c_ld  = load_en;
    c_a   = address;
    c_d   = dataW;
    c_la  = load_addr;
    c_ld_d = load_data;
    c_hit = c_wr && (int'(c_a) >= OUT_BASE) && (int'(c_a) < OUT_BASE + OUT_LEN);
    c_pop = out_ready && (exp_q.size() != 0);
    @(posedge ck);
    if (c_ld) ref_mem[c_la] = c_ld_d;
    if (c_wr) ref_mem[c_a] = c_d;
    if (c_pop) void'(exp_q.pop_front());
    if (c_hit) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({c_a, c_d});
      else ref_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ce = 0; we = 0; load_en = 0; out_ready = 0;
    address = '0; dataW = '0; load_addr = '0; load_data = '0;
  endtask

  task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ce = 1; we = 1; address = a; dataW = d;
    step();
    ce = 0; we = 0;
  endtask

  task automatic hard_reset();
    rst = 1; #1; rst = 0;
    exp_q.delete();
    ref_ovf = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge ck);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (fifo_count !== '0) begin n_bad++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_cmp++; if (out_addr !== '0) begin n_bad++; $display("FAIL reset_out_addr got %0h want 0", out_addr); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL reset_out_data got %0h want 0", out_data); end
    rst = 0;
    exp_q.delete();
    ref_ovf = 1'b0;
    // Give every RAM word a known value so later reads are comparable.
    for (int i = 0; i < 2**ADDR_W; i++) begin
      load_en = 1; load_addr = ADDR_W'(i); load_data = DATA_W'($urandom);
      step();
    end
    load_en = 0;
  endtask

  task automatic test_preload_read();
    load_en = 1; load_addr = 8'd30; load_data = 16'h000A;
    step();
    load_en = 0;
    ce = 1; address = 8'd30;
    #1;
    n_cmp++; if (dataR !== 16'h000A) begin n_bad++; $display("FAIL preload_read got %h want 000a", dataR); end
    n_cmp++; if (fifo_count !== '0) begin n_bad++; $display("FAIL preload_no_push got %0d want 0", fifo_count); end
    ce = 0;
  endtask

  task automatic test_write_outside();
    logic [DATA_W-1:0] old_v;
    old_v = ref_mem[3];
    ce = 1; we = 1; address = 8'd3; dataW = 16'h1234;
    #1;
    n_cmp++; if (dataR !== old_v) begin n_bad++; $display("FAIL write_before_edge got %h want %h", dataR, old_v); end
    step();
    ce = 0; we = 0;
    #1;
    n_cmp++; if (dataR !== 16'h1234) begin n_bad++; $display("FAIL write_after_edge got %h want 1234", dataR); end
    n_cmp++; if (fifo_count !== '0) begin n_bad++; $display("FAIL write_outside_count got %0d want 0", fifo_count); end
  endtask

  task automatic test_fifo_order();
    logic [ADDR_W-1:0] ea [3];
    logic [DATA_W-1:0] ed [3];
    ea = '{8'd15, 8'd16, 8'd17};
    ed = '{16'h0001, 16'h0002, 16'h0003};
    out_ready = 0;
    for (int i = 0; i < 3; i++) cpu_write(ea[i], ed[i]);
    n_cmp++; if (fifo_count !== CNT_W'(3)) begin n_bad++; $display("FAIL order_count got %0d want 3", fifo_count); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_addr !== ea[i] || out_data !== ed[i]) begin
        n_bad++;
        $display("FAIL order_pop%0d got v=%b %0d/%h want v=1 %0d/%h", i, out_valid, out_addr, out_data, ea[i], ed[i]);
      end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL order_empty got %b want 0", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] last_d;
    out_ready = 0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      last_d = DATA_W'($urandom);
      cpu_write(ADDR_W'(OUT_BASE + (i % OUT_LEN)), last_d);
    end
    address = ADDR_W'(OUT_BASE + (FIFO_DEPTH % OUT_LEN));
    #1;
    n_cmp++; if (fifo_count !== CNT_W'(FIFO_DEPTH)) begin n_bad++; $display("FAIL ovf_count got %0d want %0d", fifo_count, FIFO_DEPTH); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_cmp++; if (dataR !== last_d) begin n_bad++; $display("FAIL ovf_ram got %h want %h", dataR, last_d); end
    out_ready = 1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || {out_addr, out_data} !== exp_q[0]) begin
        n_bad++;
        $display("FAIL ovf_drain%0d got v=%b %h want %h", i, out_valid, {out_addr, out_data}, exp_q[0]);
      end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_dropped_absent got %b want 0", out_valid); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    out_ready = 0;
  endtask

  task automatic test_full_with_pop();
    logic [DATA_W-1:0] d24;
    hard_reset();
    out_ready = 0;
    for (int i = 0; i < FIFO_DEPTH; i++) cpu_write(ADDR_W'(OUT_BASE + i), DATA_W'($urandom));
    d24 = DATA_W'($urandom);
    out_ready = 1;
    cpu_write(8'd24, d24);
    n_cmp++; if (fifo_count !== CNT_W'(FIFO_DEPTH)) begin n_bad++; $display("FAIL fullpop_count got %0d want %0d", fifo_count, FIFO_DEPTH); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullpop_ovf got %b want 0", overflow); end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (i == FIFO_DEPTH - 1) begin
        n_cmp++;
        if (out_addr !== 8'd24 || out_data !== d24) begin
          n_bad++; $display("FAIL fullpop_last got %0d/%h want 24/%h", out_addr, out_data, d24);
        end
      end else begin
        n_cmp++;
        if ({out_addr, out_data} !== exp_q[0]) begin
          n_bad++; $display("FAIL fullpop_drain%0d got %h want %h", i, {out_addr, out_data}, exp_q[0]);
        end
      end
      step();
    end
    out_ready = 0;
  endtask

  task automatic test_boundary_reset();
    logic [DATA_W-1:0] d24;
    out_ready = 0;
    cpu_write(8'd14, 16'hAAAA);
    cpu_write(8'd25, 16'hBBBB);
    n_cmp++; if (fifo_count !== '0) begin n_bad++; $display("FAIL bound_outside got %0d want 0", fifo_count); end
    d24 = 16'hC24C;
    cpu_write(8'd24, d24);
    n_cmp++; if (fifo_count !== CNT_W'(1)) begin n_bad++; $display("FAIL bound_24 got %0d want 1", fifo_count); end
    cpu_write(8'd15, 16'h1515);
    cpu_write(8'd20, 16'h2020);
    out_ready = 1;
    step();
    // Reset between edges while entries are still queued.
    #1 rst = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    n_cmp++; if (fifo_count !== '0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", fifo_count); end
    address = 8'd24;
    #1;
    n_cmp++; if (dataR !== d24) begin n_bad++; $display("FAIL midrst_ram got %h want %h", dataR, d24); end
    rst = 0;
    exp_q.delete();
    ref_ovf = 1'b0;
    out_ready = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) != 0);
      address = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 255))
                                            : ADDR_W'($urandom_range(OUT_BASE - 3, OUT_BASE + OUT_LEN + 2));
      dataW = DATA_W'($urandom);
      out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      load_en = ($urandom_range(0, 5) == 0);
      load_addr = ($urandom_range(0, 1) != 0) ? address : ADDR_W'($urandom_range(0, 255));
      load_data = DATA_W'($urandom);
      #1;
      n_cmp++; if (dataR !== ref_mem[address]) begin n_bad++; $display("FAIL rnd_read[%0d] got %h want %h", i, dataR, ref_mem[address]); end
      step();
      n_cmp++;
      if (fifo_count !== CNT_W'(exp_q.size()) || out_valid !== (exp_q.size() != 0) || overflow !== ref_ovf) begin
        n_bad++;
        $display("FAIL rnd_state[%0d] got cnt=%0d v=%b ovf=%b want cnt=%0d ovf=%b", i, fifo_count, out_valid, overflow, exp_q.size(), ref_ovf);
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        if ({out_addr, out_data} !== exp_q[0]) begin
          n_bad++; $display("FAIL rnd_head[%0d] got %h want %h", i, {out_addr, out_data}, exp_q[0]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_write_outside();
    test_fifo_order();
    test_overflow();
    test_full_with_pop();
    test_boundary_reset();
    hard_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
